// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for pipelined_cla_addsub.
// The producer and consumer side of the unit share one interface instance.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovfl;
    logic             neg;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovfl, neg, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovfl, neg, zero
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined two-level carry-lookahead add/subtract with N/Z/V/C flags.
// Optional saturation on signed overflow when ADDSUB_SAT_EN is defined.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipelined_cla_addsub_if.slave bus
);
    localparam int SW  = WIDTH / STAGES;
    localparam int NG  = SW / 4;
    localparam int MSB = WIDTH - 1;

    // Returns {carry_out, sum} for one stage slice using group P/G lookahead.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          cin);
        logic [SW-1:0] p, g, s;
        logic [NG-1:0] pg, gg;
        logic [NG:0]   cg;
        logic [3:0]    c4;
        logic          acc, pr;
        p  = x | y;
        g  = x & y;
        s  = '0;
        c4 = '0;
        for (int j = 0; j < NG; j++) begin
            pg[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        cg[0] = cin;
        for (int j = 0; j < NG; j++) begin
            acc = gg[j];
            pr  = pg[j];
            for (int i = j - 1; i >= 0; i--) begin
                acc = acc | (pr & gg[i]);
                pr  = pr & pg[i];
            end
            cg[j+1] = acc | (pr & cin);
        end
        for (int j = 0; j < NG; j++) begin
            c4[0] = cg[j];
            c4[1] = g[4*j] | (p[4*j] & cg[j]);
            c4[2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg[j]);
            c4[3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
            for (int i = 0; i < 4; i++) begin
                s[4*j+i] = x[4*j+i] ^ y[4*j+i] ^ c4[i];
            end
        end
        return {cg[NG], s};
    endfunction

    logic             vld_q [STAGES];
    logic             vld_d [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] bop_q [STAGES];
    logic [WIDTH-1:0] bop_d [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic             cy_q  [STAGES];
    logic             cy_d  [STAGES];
    logic             ovfl_q, ovfl_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;

    logic             adv;
    logic             src_vld, src_cy, ovf;
    logic [WIDTH-1:0] src_a, src_bop, src_sum, raw, res;
    logic [SW:0]      slice;

    always_comb begin
        adv     = ~vld_q[STAGES-1] | bus.out_ready;
        vld_d   = vld_q;
        a_d     = a_q;
        bop_d   = bop_q;
        sum_d   = sum_q;
        cy_d    = cy_q;
        ovfl_d  = ovfl_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        src_vld = 1'b0;
        src_cy  = 1'b0;
        src_a   = '0;
        src_bop = '0;
        src_sum = '0;
        raw     = '0;
        res     = '0;
        ovf     = 1'b0;
        slice   = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_vld = bus.in_valid;
                src_a   = bus.a;
                src_bop = bus.sub ? ~bus.b : bus.b;
                src_sum = '0;
                src_cy  = bus.sub;
            end else begin
                src_vld = vld_q[(k == 0) ? 0 : k-1];
                src_a   = a_q[(k == 0) ? 0 : k-1];
                src_bop = bop_q[(k == 0) ? 0 : k-1];
                src_sum = sum_q[(k == 0) ? 0 : k-1];
                src_cy  = cy_q[(k == 0) ? 0 : k-1];
            end
            slice = cla_slice(src_a[k*SW +: SW], src_bop[k*SW +: SW], src_cy);
            raw   = src_sum;
            raw[k*SW +: SW] = slice[SW-1:0];
            if (adv) begin
                vld_d[k] = src_vld;
                if (k != STAGES-1) begin
                    a_d[k]   = src_a;
                    bop_d[k] = src_bop;
                    sum_d[k] = raw;
                    cy_d[k]  = slice[SW];
                end else if (src_vld && !flush) begin
                    // Output stage only moves on real results so flags/sum hold across bubbles.
                    ovf = (src_a[MSB] == src_bop[MSB]) & (raw[MSB] != src_a[MSB]);
                    res = raw;
`ifdef ADDSUB_SAT_EN
                    if (ovf) begin
                        res = src_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                    sum_d[k] = res;
                    cy_d[k]  = slice[SW];
                    ovfl_d   = ovf;
                    neg_d    = res[MSB];
                    zero_d   = ~|res;
                end
            end
            if (flush) begin
                vld_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                bop_q[k] <= '0;
                sum_q[k] <= '0;
                cy_q[k]  <= 1'b0;
            end
            ovfl_q <= 1'b0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            a_q    <= a_d;
            bop_q  <= bop_d;
            sum_q  <= sum_d;
            cy_q   <= cy_d;
            ovfl_q <= ovfl_d;
            neg_q  <= neg_d;
            zero_q <= zero_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = sum_q[STAGES-1];
    assign bus.cout      = cy_q[STAGES-1];
    assign bus.ovfl      = ovfl_q;
    assign bus.neg       = neg_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed 16-bit cases plus a 32-bit depth sweep.
// Honours ADDSUB_SAT_EN in its reference model when the build defines it.
module tb_pipelined_cla_addsub;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovfl;
        logic        neg;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush16 = 1'b0;
    logic flush32 = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    pipelined_cla_addsub_if #(.WIDTH(16)) bus16 ();
    pipelined_cla_addsub #(.WIDTH(16), .STAGES(2)) dut16 (
        .clk(clk), .rst(rst), .flush(flush16), .bus(bus16)
    );

    logic        iv32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        s32 = 1'b0;
    logic [3:0]  o_valid;
    logic [35:0] o_res [4];

    for (genvar g = 0; g < 4; g++) begin : sw
        pipelined_cla_addsub_if #(.WIDTH(32)) bus ();
        pipelined_cla_addsub #(.WIDTH(32), .STAGES(1 << g)) dut (
            .clk(clk), .rst(rst), .flush(flush32), .bus(bus)
        );
        assign bus.in_valid  = iv32;
        assign bus.a         = a32;
        assign bus.b         = b32;
        assign bus.sub       = s32;
        assign bus.out_ready = 1'b1;
        assign o_valid[g]    = bus.out_valid;
        assign o_res[g]      = {bus.sum, bus.cout, bus.ovfl, bus.neg, bus.zero};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t ref_calc(input int w, input longint unsigned a,
                                      input longint unsigned b, input bit s);
        res_t r;
        longint unsigned mask, u;
        longint sa, sb, v, hi, lo;
        mask = (64'd1 << w) - 1;
        sa = longint'(a);
        sb = longint'(b);
        if (((a >> (w-1)) & 1) == 1) sa = sa - (longint'(1) << w);
        if (((b >> (w-1)) & 1) == 1) sb = sb - (longint'(1) << w);
        v  = s ? sa - sb : sa + sb;
        hi = (longint'(1) << (w-1)) - 1;
        lo = -(longint'(1) << (w-1));
        u  = (s ? a - b : a + b) & mask;
        r.ovfl = (v > hi) || (v < lo);
        r.cout = s ? (a >= b) : (((a + b) >> w) & 1) == 1;
`ifdef ADDSUB_SAT_EN
        if (r.ovfl) u = (v > hi) ? longint'(hi) : (longint'(lo) & mask);
`endif
        r.sum  = 32'(u);
        r.neg  = ((u >> (w-1)) & 1) == 1;
        r.zero = (u == 0);
        return r;
    endfunction

    // 16-bit scoreboard state
    res_t        q16[$];
    bit          stall_prev = 0;
    logic [20:0] held = '0;
    int          got16 = 0;

    task automatic step16(input bit iv, input logic [15:0] a, input logic [15:0] b,
                          input bit s, input bit ordy, input bit fl);
        res_t e;
        bus16.in_valid  = iv;
        bus16.a         = a;
        bus16.b         = b;
        bus16.sub       = s;
        bus16.out_ready = ordy;
        flush16         = fl;
        #1;
        chk("in_ready", bus16.in_ready, !(bus16.out_valid && !ordy));
        if (stall_prev)
            chk("hold", {bus16.out_valid, bus16.sum, bus16.cout, bus16.ovfl, bus16.neg, bus16.zero}, held);
        if (bus16.out_valid && ordy && !fl) begin
            chk("spurious", q16.size() > 0, 1);
            if (q16.size() > 0) begin
                e = q16.pop_front();
                chk("result", {16'h0, bus16.sum, bus16.cout, bus16.ovfl, bus16.neg, bus16.zero}, e);
                got16++;
            end
        end
        stall_prev = bus16.out_valid && !ordy && !fl;
        held = {bus16.out_valid, bus16.sum, bus16.cout, bus16.ovfl, bus16.neg, bus16.zero};
        if (fl) q16.delete();
        else if (iv && bus16.in_ready) q16.push_back(ref_calc(16, a, b, s));
        @(negedge clk);
    endtask

    task automatic dir16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] es, input logic ec,
                         input logic eo, input logic en, input logic ez);
        int n;
        n = 0;
        bus16.in_valid  = 1'b1;
        bus16.a         = a;
        bus16.b         = b;
        bus16.sub       = s;
        bus16.out_ready = 1'b1;
        flush16         = 1'b0;
        do begin
            @(negedge clk);
            n++;
            bus16.in_valid = 1'b0;
        end while (!bus16.out_valid && n < 8);
        chk({tag, "_lat"}, n, 2);
        chk({tag, "_res"}, {bus16.sum, bus16.cout, bus16.ovfl, bus16.neg, bus16.zero},
            {es, ec, eo, en, ez});
    endtask

    bit          hv [2048];
    logic [31:0] ha [2048];
    logic [31:0] hb [2048];
    bit          hs [2048];

    initial begin
        int nops, last, idx, ng;
        res_t r;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.sub       = 1'b0;
        bus16.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_valid", bus16.out_valid, 0);
        chk("rst_ready", bus16.in_ready, 1);
        chk("rst_out", {bus16.sum, bus16.cout, bus16.ovfl, bus16.neg, bus16.zero}, 0);
        chk("rst_valid32", o_valid, 0);

        // 32-bit sweep over STAGES = 1, 2, 4, 8 with a free-running consumer
        nops = 0;
        last = 0;
        for (int t = 0; t < 2000; t++) begin
            for (int g = 0; g < 4; g++) begin
                idx = t - (1 << g);
                chk($sformatf("sw%0d_valid", g), o_valid[g], (idx >= 0) ? hv[idx] : 1'b0);
                if (idx >= 0 && hv[idx]) begin
                    r = ref_calc(32, ha[idx], hb[idx], hs[idx]);
                    chk($sformatf("sw%0d_res", g), o_res[g], r);
                end
            end
            hv[t] = (nops < 1000) && ($urandom_range(0, 7) != 0);
            ha[t] = $urandom;
            hb[t] = $urandom;
            if ($urandom_range(0, 3) == 0) hb[t] = ha[t] + 32'($urandom_range(0, 2)) - 32'd1;
            hs[t] = $urandom_range(0, 1) == 1;
            iv32 = hv[t];
            a32  = ha[t];
            b32  = hb[t];
            s32  = hs[t];
            if (hv[t]) begin
                nops++;
                last = t;
            end
            @(negedge clk);
            if (nops >= 1000 && t > last + 10) break;
        end
        chk("sweep_ops", nops, 1000);
        iv32 = 1'b0;

        // Directed 16-bit cases
`ifdef ADDSUB_SAT_EN
        dir16("pos_ovf", 16'h7FFF, 16'h0001, 0, 16'h7FFF, 0, 1, 0, 0);
        dir16("neg_ovf", 16'h8000, 16'h0001, 1, 16'h8000, 1, 1, 1, 0);
`else
        dir16("pos_ovf", 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 1, 0);
        dir16("neg_ovf", 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1, 0, 0);
`endif
        dir16("sub_eq",   16'h0005, 16'h0005, 1, 16'h0000, 1, 0, 0, 1);
        dir16("stage_cy", 16'h00FF, 16'h0001, 0, 16'h0100, 0, 0, 0, 0);
        dir16("wrap",     16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 0, 1);
        dir16("borrow",   16'h0003, 16'h0005, 1, 16'hFFFE, 0, 0, 1, 0);
        bus16.out_ready = 1'b1;
        @(negedge clk);

        // Back-pressure: 6 back-to-back ops, consumer stalls 3 cycles mid-stream
        got16 = 0;
        ng = 0;
        for (int i = 0; i < 20; i++) begin
            step16(ng < 6, 16'($urandom), 16'($urandom), $urandom_range(0, 1) == 1,
                   !(i >= 3 && i < 6), 0);
            if (ng < 6 && !stall_prev && q16.size() + got16 > ng) ng++;
        end
        chk("bp_count", got16, 6);
        chk("bp_empty", q16.size(), 0);

        // Flush with two ops in flight
        step16(1, 16'h1234, 16'h1111, 0, 1, 0);
        step16(1, 16'h4321, 16'h0101, 1, 1, 0);
        step16(1, 16'h0F0F, 16'h0001, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("flush_drop", bus16.out_valid, 0);
            step16(0, 16'h0, 16'h0, 0, 1, 0);
        end
        dir16("post_flush", 16'h1000, 16'h0234, 0, 16'h1234, 0, 0, 0, 0);
        bus16.out_ready = 1'b1;
        @(negedge clk);

        // Reset with two ops in flight
        step16(1, 16'hAAAA, 16'h5555, 0, 1, 0);
        step16(1, 16'h0001, 16'h0002, 1, 1, 0);
        rst = 1'b1;
        bus16.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q16.delete();
        stall_prev = 0;
        #1;
        chk("rst2_out", {bus16.out_valid, bus16.sum, bus16.cout, bus16.ovfl, bus16.neg, bus16.zero}, 0);
        chk("rst2_ready", bus16.in_ready, 1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst2_drop", bus16.out_valid, 0);
            @(negedge clk);
        end

        // Random traffic with random back-pressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            bit fl;
            fl = $urandom_range(0, 49) == 0;
            step16($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                   $urandom_range(0, 1) == 1, !fl && ($urandom_range(0, 9) < 7), fl);
        end
        for (int i = 0; i < 6; i++) step16(0, 16'h0, 16'h0, 0, 1, 0);
        chk("rand_drain", q16.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
